// File: rtl/riscv_mem_stage.sv
// MEM stage: issues data-memory loads/stores over a req/ack bus, stalling the pipeline while busy.
// Latency is >=3 cycles per memory op (IDLE, BUSY x (1+waits), DONE). Non-memory instructions pass straight through.
module riscv_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  input  logic [2:0]  funct3_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] pc_plus4_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic        jump_in,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] pc_plus4_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic        jump_out,
  output logic        stall,
  output logic        mem_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_dmem_wstrb;
  logic [31:0] r_load_buf;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;

  logic        w_mem_op;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_fault;
  logic        w_accept;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_shifted;
  logic [31:0] w_load_ext;

  assign w_mem_op = mem_read_in | mem_write_in;

  // A request with both read and write set is treated as a store.
  always_comb begin
    w_illegal = 1'b0;
    if (mem_write_in)
      w_illegal = !(funct3_in inside {3'b000, 3'b001, 3'b010});
    else
      w_illegal = !(funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    w_misalign = ((funct3_in[1:0] == 2'b01) && alu_result_in[0]) ||
                 ((funct3_in[1:0] == 2'b10) && (alu_result_in[1:0] != 2'b00));
    w_fault = w_illegal | w_misalign;
  end

  assign w_accept = (r_state == S_IDLE) && w_mem_op && !w_fault;

  always_comb begin
    w_wdata = rs2_data_in;
    w_wstrb = 4'b1111;
    case (funct3_in[1:0])
      2'b00: begin
        w_wdata = {4{rs2_data_in[7:0]}};
        w_wstrb = 4'b0001 << alu_result_in[1:0];
      end
      2'b01: begin
        w_wdata = {2{rs2_data_in[15:0]}};
        w_wstrb = alu_result_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = rs2_data_in;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  assign w_shifted = dmem_rdata >> {r_addr_lo, 3'b000};

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_ext = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_ext = {16'd0, w_shifted[15:0]};
      default: w_load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_dmem_wstrb <= 4'd0;
      r_load_buf   <= 32'd0;
      r_funct3     <= 3'd0;
      r_addr_lo    <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= mem_write_in;
            r_dmem_addr  <= {alu_result_in[31:2], 2'b00};
            r_dmem_wdata <= mem_write_in ? w_wdata : 32'd0;
            r_dmem_wstrb <= mem_write_in ? w_wstrb : 4'd0;
            r_funct3     <= funct3_in;
            r_addr_lo    <= alu_result_in[1:0];
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            r_dmem_req <= 1'b0;
            if (!r_dmem_we)
              r_load_buf <= w_load_ext;
            r_state <= S_DONE;
          end
        end
        // Inputs still hold the finished instruction here; never re-examine them.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall          = w_accept || (r_state == S_BUSY);
  assign mem_fault      = w_mem_op & w_fault;
  assign mem_data_out   = (r_state == S_DONE) ? r_load_buf : 32'd0;
  assign alu_result_out = alu_result_in;
  assign rd_addr_out    = rd_addr_in;
  assign pc_plus4_out   = pc_plus4_in;
  assign reg_write_out  = reg_write_in & ~mem_fault;
  assign mem_to_reg_out = mem_to_reg_in;
  assign jump_out       = jump_in;
  assign dmem_req       = r_dmem_req;
  assign dmem_we        = r_dmem_we;
  assign dmem_addr      = r_dmem_addr;
  assign dmem_wdata     = r_dmem_wdata;
  assign dmem_wstrb     = r_dmem_wstrb;

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Randomized + directed bench for riscv_mem_stage against a transaction-level reference model.
module tb_riscv_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_in, rs2_data_in, pc_plus4_in;
  logic [2:0]  funct3_in;
  logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in, jump_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] alu_result_out, mem_data_out, pc_plus4_out;
  logic [4:0]  rd_addr_out;
  logic        reg_write_out, mem_to_reg_out, jump_out, stall, mem_fault;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  int          errors = 0;
  int          checks = 0;
  int          req_cnt, stall_cnt;
  logic [31:0] m_load_buf;

  always #5 clk = ~clk;

  riscv_mem_stage dut (
    .clk(clk), .rst(rst),
    .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in), .funct3_in(funct3_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .rd_addr_in(rd_addr_in),
    .pc_plus4_in(pc_plus4_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .jump_in(jump_in),
    .alu_result_out(alu_result_out), .mem_data_out(mem_data_out), .rd_addr_out(rd_addr_out),
    .pc_plus4_out(pc_plus4_out), .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .jump_out(jump_out), .stall(stall), .mem_fault(mem_fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_nop();
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b0;
    funct3_in     = 3'($urandom_range(0, 7));
    alu_result_in = $urandom;
    rs2_data_in   = $urandom;
  endtask

  // Drives one instruction from its first MEM cycle to the cycle after it leaves MEM.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int waits);
    logic        is_mem, fault, rw;
    logic [31:0] exp_wdata, exp_ld, v;
    logic [3:0]  exp_wstrb;
    int          lo, size;
    is_mem = rd | wr;
    lo     = int'(addr % 4);
    size   = int'(f3 % 4);
    if (wr) fault = !(f3 == 0 || f3 == 1 || f3 == 2);
    else    fault = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (size == 1 && (lo % 2) != 0) fault = 1'b1;
    if (size == 2 && lo != 0)       fault = 1'b1;
    fault = fault & is_mem;
    case (size)
      0:       begin exp_wdata = (rs2 & 32'hFF) * 32'h01010101;   exp_wstrb = 4'(1 << lo); end
      1:       begin exp_wdata = (rs2 & 32'hFFFF) * 32'h00010001; exp_wstrb = (lo >= 2) ? 4'hC : 4'h3; end
      default: begin exp_wdata = rs2;                             exp_wstrb = 4'hF; end
    endcase
    if (size == 0) begin
      v = (rdata >> (8 * lo)) & 32'hFF;
      if (f3 == 0 && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = (rdata >> (16 * (lo / 2))) & 32'hFFFF;
      if (f3 == 1 && v >= 32768) v = v - 65536;
    end else v = rdata;
    exp_ld = v;

    rw = 1'($urandom_range(0, 1));
    mem_read_in = rd; mem_write_in = wr; funct3_in = f3;
    alu_result_in = addr; rs2_data_in = rs2;
    rd_addr_in = 5'($urandom); pc_plus4_in = $urandom; reg_write_in = rw;
    mem_to_reg_in = 1'($urandom); jump_in = 1'($urandom);
    dmem_ack = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    req_cnt = 0; stall_cnt = 0;

    @(negedge clk);
    if (stall) stall_cnt++;
    if (dmem_req) req_cnt++;
    check("idle_stall", 32'(stall), 32'(is_mem & ~fault));
    check("idle_fault", 32'(mem_fault), 32'(fault));
    check("idle_regwr", 32'(reg_write_out), 32'(rw & ~fault));
    check("idle_req", 32'(dmem_req), 32'd0);
    check("idle_mdata", mem_data_out, 32'd0);
    check("pass_alu", alu_result_out, addr);
    check("pass_pc", pc_plus4_out, pc_plus4_in);
    check("pass_ctl", {25'd0, rd_addr_out, mem_to_reg_out, jump_out},
          {25'd0, rd_addr_in, mem_to_reg_in, jump_in});
    @(posedge clk); #1;
    if (!is_mem || fault) return;

    for (int k = 0; k <= waits; k++) begin
      dmem_ack   = (k == waits);
      dmem_rdata = (k == waits) ? rdata : $urandom;
      @(negedge clk);
      if (stall) stall_cnt++;
      if (dmem_req) req_cnt++;
      check("busy_req", 32'(dmem_req), 32'd1);
      check("busy_stall", 32'(stall), 32'd1);
      check("busy_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check("busy_we", 32'(dmem_we), 32'(wr));
      check("busy_wstrb", 32'(dmem_wstrb), wr ? 32'(exp_wstrb) : 32'd0);
      if (wr) check("busy_wdata", dmem_wdata, exp_wdata);
      check("busy_mdata", mem_data_out, 32'd0);
      @(posedge clk); #1;
    end
    if (!wr) m_load_buf = exp_ld;

    dmem_ack   = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    @(negedge clk);
    if (stall) stall_cnt++;
    if (dmem_req) req_cnt++;
    check("done_req", 32'(dmem_req), 32'd0);
    check("done_stall", 32'(stall), 32'd0);
    check("done_mdata", mem_data_out, m_load_buf);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    rd_addr_in = 5'd0; pc_plus4_in = 32'd0; reg_write_in = 1'b0;
    mem_to_reg_in = 1'b0; jump_in = 1'b0;
    set_nop();
    m_load_buf = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wstrb", 32'(dmem_wstrb), 32'd0);
    check("rst_mdata", mem_data_out, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;

    run_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2);
    check("sw_req_cycles", 32'(req_cnt), 32'd3);
    check("sw_stall_cycles", 32'(stall_cnt), 32'd4);
    run_op(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0);
    run_op(1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 0);
    check("lb_val", m_load_buf, 32'hFFFFFF80);
    run_op(1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 0);
    check("lbu_val", m_load_buf, 32'h00000080);
    run_op(1, 0, 3'b001, 32'h102, 32'h0, 32'h8001ABCD, 1);
    check("lh_val", m_load_buf, 32'hFFFF8001);
    run_op(1, 0, 3'b101, 32'h102, 32'h0, 32'h8001ABCD, 0);
    check("lhu_val", m_load_buf, 32'h00008001);
    run_op(0, 1, 3'b001, 32'h102, 32'h1234, 32'h0, 0);
    run_op(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    run_op(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    run_op(1, 0, 3'b010, 32'h300, 32'h0, 32'h11112222, 0);
    run_op(0, 0, 3'b000, 32'h5, 32'h6, 32'h0, 0);
    run_op(1, 0, 3'b010, 32'h304, 32'h0, 32'h33334444, 0);
    run_op(1, 0, 3'b010, 32'h308, 32'h0, 32'h55556666, 0);

    for (int n = 0; n < 80; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      run_op(kind[0], kind[1], 3'($urandom_range(0, 7)),
             {20'd0, 10'($urandom), 2'($urandom)}, $urandom, $urandom, $urandom_range(0, 3));
    end

    // Reset in the second BUSY cycle of a store; a late ack must be ignored.
    mem_read_in = 1'b0; mem_write_in = 1'b1; funct3_in = 3'b010;
    alu_result_in = 32'h40; rs2_data_in = 32'hCAFEF00D; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("prerst_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    set_nop();
    dmem_ack = 1'b1;
    m_load_buf = 32'd0;
    @(negedge clk);
    check("post_rst_req", 32'(dmem_req), 32'd0);
    check("post_rst_we", 32'(dmem_we), 32'd0);
    check("post_rst_addr", dmem_addr, 32'd0);
    check("post_rst_wdata", dmem_wdata, 32'd0);
    check("post_rst_wstrb", 32'(dmem_wstrb), 32'd0);
    check("post_rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check("late_ack_mdata", mem_data_out, 32'd0);
    @(posedge clk); #1;
    run_op(1, 0, 3'b010, 32'h40, 32'h0, 32'h0BADBEEF, 1);
    check("recover_lw", m_load_buf, 32'h0BADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
